// File: rtl/cla_serial_controller.sv
// Serial WIDTH-bit add/subtract sequencer built around one 4-bit carry-lookahead slice.
// Processes one nibble per clock, LSB first, with valid/ready handshakes on both sides.

module cla_sum_generator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c_msb,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // All carries are flattened lookahead terms, so no carry ripples through the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum   = p ^ c[3:0];
  assign c_msb = c[3];
  assign cout  = c[4];
endmodule

module cla_serial_controller #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = $clog2(NSLICE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       slice_sum;
  logic             slice_c_msb;
  logic             slice_cout;
  logic [WIDTH-1:0] next_result;
  logic             last_nib;
  logic             accept;

  cla_sum_generator u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .cin   (carry_r),
    .sum   (slice_sum),
    .c_msb (slice_c_msb),
    .cout  (slice_cout)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_nib  = (idx == IDX_W'(NSLICE - 1));

  // Nibble mux into the shared slice, and the result with the current nibble replaced.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    a_nib       = '0;
    b_nib       = '0;
    next_result = result;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib                 = a_r[4*i +: 4];
        b_nib                 = b_r[4*i +: 4];
        next_result[4*i +: 4] = slice_sum;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_nib) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: sequential state always uses non-blocking assignment so every register samples pre-edge values.
    else        state <= state_next;
  end

  // Datapath: operands are captured only on acceptance; subtract is A + ~B + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      carry_r   <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      a_r     <= op_a;
      b_r     <= op_sub ? ~op_b : op_b;
      carry_r <= op_sub;
      idx     <= '0;
    end else if (state == RUN) begin
      result  <= next_result;
      carry_r <= slice_cout;
      idx     <= idx + 1'b1;
      if (last_nib) begin
        carry_out <= slice_cout;
        overflow  <= slice_cout ^ slice_c_msb;
        zero      <= (next_result == '0);
        idx       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cla_serial_controller.sv
// Self-checking bench for cla_serial_controller: directed corner cases, backpressure,
// mid-operation reset and 200 random back-to-back operations against an arithmetic model.

module tb_cla_serial_controller;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int accepts     = 0;
  int last_acc    = -1;

  cla_serial_controller #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) accepts <= accepts + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain WIDTH-bit arithmetic; carry means "no borrow" when subtracting.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                output logic [15:0] r, output logic c, output logic v,
                                output logic z);
    logic [16:0] full;
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b};
      r    = full[15:0];
      c    = full[16];
      v    = (a[15] == b[15]) && (r[15] != a[15]);
    end else begin
      r = a - b;
      c = (a >= b);
      v = (a[15] != b[15]) && (r[15] != a[15]);
    end
    z = (r == 16'h0000);
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input int stall, input bit hold_valid, input bit check_gap);
    logic [15:0] er;
    logic        ec, ev, ez;
    int          n;
    int          lat;
    int          acc0;
    model(a, b, sub, er, ec, ev, ez);

    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end

    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    @(posedge clk);
    #1;
    if (check_gap && last_acc >= 0) check("issue_gap_ge6", 32'((cyc - last_acc) >= 6), 32'd1);
    last_acc = cyc;
    acc0     = accepts;

    // Operands change after acceptance; they must have no effect.
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
    op_sub   = 1'($urandom);
    in_valid = hold_valid;

    // Latency counted inclusive of the acceptance cycle.
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 32'(lat), 32'd5);
    if (!out_valid) return;

    check("result", 32'(result), 32'(er));
    check("carry_out", 32'(carry_out), 32'(ec));
    check("overflow", 32'(overflow), 32'(ev));
    check("zero", 32'(zero), 32'(ez));

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_result", 32'(result), 32'(er));
      check("stall_flags", {29'd0, carry_out, overflow, zero}, {29'd0, ec, ev, ez});
    end
    if (hold_valid) begin
      check("no_second_accept", 32'(accepts), 32'(acc0));
      in_valid = 1'b0;
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0, 1'b0);
    run_op(16'hA5A5, 16'h1234, 1'b1, 10, 1'b1, 1'b0);

    // Reset during the second RUN cycle of 0x1234 + 0x4321.
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = 16'h1234;
    op_b     = 16'h4321;
    op_sub   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("busy_before_reset", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, 1'b0);

    last_acc = -1;
    for (int k = 0; k < 200; k++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
